// File: rtl/row_issue_sequencer.sv
// row_issue_sequencer: streams NUM_ROWS matrix rows from a row memory into a
// row-by-vector dot-product unit and collects one result per row, tagged with
// its row index. A PIPE_LAT-deep valid shift register tracks rows in flight.
// Optional feature macro: SEQ_STALL_EN (stall input holds row issue when defined;
// when undefined the stall port is present but ignored).
module row_issue_sequencer #(
  parameter int unsigned NUM_ROWS = 8,
  parameter int unsigned PIPE_LAT = 12,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [95:0]       p_vec,
  input  logic              stall,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [95:0]       mem_rdata,
  output logic [95:0]       a_out,
  output logic [95:0]       p_out,
  input  logic [31:0]       result_in,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_index,
  output logic [31:0]       res_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   res_cnt;
  logic                issue;
  logic                issue_d;
  logic [PIPE_LAT-1:0] vld_sr;
  logic                hold;

`ifdef SEQ_STALL_EN
  assign hold = stall;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign hold         = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and row-issue strobe
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: begin
        issue = !hold;
        if (!hold && addr == LAST_ROW) state_nxt = DRAIN;
      end
      DRAIN: if (res_valid && res_cnt == LAST_ROW) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: vector capture, row address, row register, in-flight tracking, result count
  always_ff @(posedge clk) begin
    if (rst) begin
      addr    <= '0;
      res_cnt <= '0;
      issue_d <= 1'b0;
      vld_sr  <= '0;
      a_out   <= '0;
      p_out   <= '0;
    end else begin
      if (state == IDLE && start) begin
        p_out   <= p_vec;
        addr    <= '0;
        res_cnt <= '0;
      end else begin
        if (issue)     addr    <= addr + 1'b1;
        if (res_valid) res_cnt <= res_cnt + 1'b1;
      end
      // Row data arrives the cycle after the read; the valid bit enters the
      // shift register on the same edge that loads a_out.
      issue_d <= issue;
      if (issue_d) a_out <= mem_rdata;
      vld_sr    <= vld_sr << 1;
      vld_sr[0] <= issue_d;
    end
  end

  assign mem_rd_en = issue;
  assign mem_addr  = addr;
  assign res_valid = vld_sr[PIPE_LAT-1];
  assign res_index = res_cnt;
  assign res_data  = res_valid ? result_in : '0;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_row_issue_sequencer.sv
// Directed bench for row_issue_sequencer: a 4-row instance and a 1-row instance,
// with a row memory and a fixed-delay stand-in for the dot-product unit
// (p0 = 1.0, so each result equals the row's a0 word).
module tb_row_issue_sequencer;

`ifdef SEQ_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  localparam logic [95:0] P1 = {32'h0, 32'h0, 32'h3F800000};
  localparam logic [95:0] P2 = {32'h40000000, 32'h0, 32'h3F800000};

  typedef struct {
    int          c;
    int unsigned v;
    logic [31:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic rst, stall;
  logic start_a, start_b;
  logic [95:0] p_vec_a, p_vec_b;
  int cyc = 0;
  int nchecks = 0;
  int nerrors = 0;

  // DUT A (NUM_ROWS=4) signals
  logic        rd_a, rv_a, busy_a, done_a;
  logic [7:0]  addr_a, idx_a;
  logic [95:0] rdata_a, aout_a, pout_a;
  logic [31:0] rin_a, rdat_a;
  logic [31:0] dl_a [11];
  // DUT B (NUM_ROWS=1) signals
  logic        rd_b, rv_b, busy_b, done_b;
  logic [7:0]  addr_b, idx_b;
  logic [95:0] rdata_b, aout_b, pout_b;
  logic [31:0] rin_b, rdat_b;
  logic [31:0] dl_b [11];

  ev_t rd_q[$], rv_q[$], rdb_q[$], rvb_q[$];
  int  done_q[$], doneb_q[$];

  row_issue_sequencer #(.NUM_ROWS(4), .PIPE_LAT(12), .ADDR_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .p_vec(p_vec_a), .stall(stall),
    .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .a_out(aout_a), .p_out(pout_a), .result_in(rin_a),
    .res_valid(rv_a), .res_index(idx_a), .res_data(rdat_a),
    .busy(busy_a), .done(done_a)
  );

  row_issue_sequencer #(.NUM_ROWS(1), .PIPE_LAT(12), .ADDR_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .p_vec(p_vec_b), .stall(stall),
    .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .a_out(aout_b), .p_out(pout_b), .result_in(rin_b),
    .res_valid(rv_b), .res_index(idx_b), .res_data(rdat_b),
    .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] row_word(input logic [7:0] a);
    case (a)
      8'd0: return 32'h3F800000;
      8'd1: return 32'h40000000;
      8'd2: return 32'h40400000;
      8'd3: return 32'h40800000;
      default: return 32'h0;
    endcase
  endfunction

  // Row memories, dot-product stand-ins and cycle counter
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_a) rdata_a <= {64'h0, row_word(addr_a)};
    if (rd_b) rdata_b <= {64'h0, row_word(addr_b)};
    dl_a[0] <= aout_a[31:0];
    dl_b[0] <= aout_b[31:0];
    for (int i = 1; i < 11; i++) begin
      dl_a[i] <= dl_a[i-1];
      dl_b[i] <= dl_b[i-1];
    end
  end
  assign rin_a = dl_a[10];
  assign rin_b = dl_b[10];

  // Event recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (rd_a)   rd_q.push_back('{cyc, 32'(addr_a), 32'h0});
    if (rv_a)   rv_q.push_back('{cyc, 32'(idx_a), rdat_a});
    if (done_a) done_q.push_back(cyc);
    if (rd_b)   rdb_q.push_back('{cyc, 32'(addr_b), 32'h0});
    if (rv_b)   rvb_q.push_back('{cyc, 32'(idx_b), rdat_b});
    if (done_b) doneb_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    rd_q.delete(); rv_q.delete(); done_q.delete();
    rdb_q.delete(); rvb_q.delete(); doneb_q.delete();
  endtask

  // Drives one scripted run on DUT A; t0 is the cycle of the start that is expected to complete
  task automatic run_a(input bit dbl, input bit stl, input bit rs, output int t0);
    int tb0;
    tb0 = cyc;
    t0  = rs ? tb0 + 10 : tb0;
    for (int k = 0; k < 36; k++) begin
      start_a = (k == 0) || (dbl && k == 6) || (rs && k == 10);
      p_vec_a = (k == 0) ? P1 : P2;
      stall   = stl && k >= 3 && k <= 5;
      rst     = rs && k == 8;
      if (k == 2) check("busy_mid", 96'(busy_a), 96'(1));
      if (rs && k == 9) begin
        check("rst_busy", 96'(busy_a), 96'(0));
        check("rst_done", 96'(done_a), 96'(0));
        check("rst_rd", 96'(rd_a), 96'(0));
        check("rst_addr", 96'(addr_a), 96'(0));
        check("rst_aout", aout_a, 96'(0));
        check("rst_pout", pout_a, 96'(0));
        check("rst_rv", 96'(rv_a), 96'(0));
        check("rst_idx", 96'(idx_a), 96'(0));
        check("rst_rdat", 96'(rdat_a), 96'(0));
      end
      step();
    end
    start_a = 1'b0;
    stall   = 1'b0;
    rst     = 1'b0;
  endtask

  // Checks reads, results and done after cycle t0 against hand-computed timing
  task automatic check_run(input int t0, input bit stl);
    int  rdc[4], rvc[4], dc;
    ev_t f[$];
    int  dn[$];
    logic [31:0] words[4];
    words = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    if (stl && STALL_ON) begin
      rdc = '{1, 2, 6, 7};     rvc = '{14, 15, 19, 20}; dc = 21;
    end else begin
      rdc = '{1, 2, 3, 4};     rvc = '{14, 15, 16, 17}; dc = 18;
    end
    f = rd_q.find(e) with (e.c > t0);
    check("rd_count", 96'(f.size()), 96'(4));
    for (int i = 0; i < 4 && i < f.size(); i++) begin
      check("rd_cycle", 96'(f[i].c - t0), 96'(rdc[i]));
      check("rd_addr", 96'(f[i].v), 96'(i));
    end
    f = rv_q.find(e) with (e.c > t0);
    check("rv_count", 96'(f.size()), 96'(4));
    for (int i = 0; i < 4 && i < f.size(); i++) begin
      check("rv_cycle", 96'(f[i].c - t0), 96'(rvc[i]));
      check("rv_index", 96'(f[i].v), 96'(i));
      check("rv_data", 96'(f[i].d), 96'(words[i]));
    end
    dn = done_q.find(e) with (e > t0);
    check("done_count", 96'(dn.size()), 96'(1));
    if (dn.size() > 0) check("done_cycle", 96'(dn[0] - t0), 96'(dc));
    check("busy_end", 96'(busy_a), 96'(0));
  endtask

  initial begin
    int t0, tr;
    ev_t f[$];
    rst = 1'b1; stall = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    p_vec_a = '0; p_vec_b = '0;
    rdata_a = '0; rdata_b = '0;
    repeat (3) step();
    check("por_busy", 96'(busy_a), 96'(0));
    check("por_rd", 96'(rd_a), 96'(0));
    check("por_aout", aout_a, 96'(0));
    check("por_pout", pout_a, 96'(0));
    check("por_rv", 96'(rv_a), 96'(0));
    check("por_done_b", 96'(done_b), 96'(0));
    rst = 1'b0;
    step();

    // Basic run with an ignored second start
    clear_q();
    run_a(1'b1, 1'b0, 1'b0, t0);
    check_run(t0, 1'b0);
    check("pout_held", pout_a, P1);

    // Stalled run (stall ignored unless SEQ_STALL_EN)
    clear_q();
    run_a(1'b0, 1'b1, 1'b0, t0);
    check_run(t0, 1'b1);

    // Reset mid-run, then a fresh run
    clear_q();
    run_a(1'b0, 1'b0, 1'b1, t0);
    tr = t0 - 10;
    f = rv_q.find(e) with (e.c > tr + 8 && e.c <= t0);
    check("rv_after_rst", 96'(f.size()), 96'(0));
    check("rv_total", 96'(rv_q.size()), 96'(4));
    check_run(t0, 1'b0);
    check("pout_new", pout_a, P2);

    // Single-row instance
    clear_q();
    t0 = cyc;
    start_b = 1'b1; p_vec_b = P2;
    step();
    start_b = 1'b0;
    repeat (20) step();
    check("b_rd_count", 96'(rdb_q.size()), 96'(1));
    if (rdb_q.size() > 0) begin
      check("b_rd_cycle", 96'(rdb_q[0].c - t0), 96'(1));
      check("b_rd_addr", 96'(rdb_q[0].v), 96'(0));
    end
    check("b_rv_count", 96'(rvb_q.size()), 96'(1));
    if (rvb_q.size() > 0) begin
      check("b_rv_cycle", 96'(rvb_q[0].c - t0), 96'(14));
      check("b_rv_index", 96'(rvb_q[0].v), 96'(0));
      check("b_rv_data", 96'(rvb_q[0].d), 96'(32'h3F800000));
    end
    check("b_done_count", 96'(doneb_q.size()), 96'(1));
    if (doneb_q.size() > 0) check("b_done_cycle", 96'(doneb_q[0] - t0), 96'(15));
    check("b_pout", pout_b, P2);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
